// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Misaligned or beyond the last implemented word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core load/store path and the data-memory responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram_be.sv
// Word-organised data RAM: synchronous byte-enabled write, registered read. Contents are not reset.
module dmem_ram_be
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, valid/ready channels.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          ZERO_LAT  = (LATENCY == 0);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d, cur_req;
  logic        err_q, err_d;
  logic        load_q, load_d;
  logic        accept, commit, cur_err, ram_we, ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_rdata;

  // With zero latency the commit happens on the accept edge, so the RAM sees the live bus
  // request; otherwise it sees the request latched at acceptance.
  always_comb begin
    cur_req = req_q;
    if (state_q == S_IDLE) begin
      cur_req.write = bus.req_write;
      cur_req.addr  = bus.req_addr;
      cur_req.wdata = bus.req_wdata;
      cur_req.be    = bus.req_be;
    end
    accept  = bus.req_valid && (state_q == S_IDLE);
    commit  = reset && (ZERO_LAT ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd1)));
    cur_err = addr_err(cur_req.addr, DEPTH_WORDS);
    ram_we  = commit && cur_req.write && !cur_err;
    ram_re  = commit && !cur_req.write && !cur_err;
    ram_idx = cur_req.addr[IDX_W+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    load_d  = load_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d   = cur_req;
          cnt_d   = 4'(LATENCY);
          state_d = ZERO_LAT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          load_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d  = cur_err;
      load_d = ram_re;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  dmem_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (cur_req.be),
    .idx   (ram_idx),
    .wdata (cur_req.wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register holds its value through RESP; load_q gates it to zero otherwise.
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = load_q ? ram_rdata : '0;

endmodule
